// File: rtl/fractal_pkg.sv
// Shared sizing defaults and collector state type for the
// Mandelbrot core dispatcher.
package fractal_pkg;

  localparam int NUM_CORES = 10;
  localparam int JOB_W     = 32;
  localparam int RES_W     = 16;
  localparam int IDX_W     = 4;

  typedef enum logic {
    IDLE,
    HOLD
  } coll_state_e;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
module priority_encoder #(
  parameter int W  = 10,
  parameter int IW = 4
) (
  input  logic [W-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/core_dispatcher.sv
// Dispatches pixel jobs to iteration cores and drains results round-robin.
// Optional DISPATCH_STATS_EN adds job/result/stall counters.
module core_dispatcher
  import fractal_pkg::*;
#(
  parameter int NUM_CORES = fractal_pkg::NUM_CORES,
  parameter int JOB_W     = fractal_pkg::JOB_W,
  parameter int RES_W     = fractal_pkg::RES_W,
  parameter int IDX_W     = fractal_pkg::IDX_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [JOB_W-1:0]           job_data,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [JOB_W-1:0]           core_job,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES*RES_W-1:0] core_result,
  output logic [NUM_CORES-1:0]       core_ack,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [RES_W-1:0]           res_data,
  output logic [IDX_W-1:0]           res_core,
  output logic                       all_idle
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                stat_jobs,
  output logic [31:0]                stat_results,
  output logic [31:0]                stat_stalls
`endif
);

  coll_state_e state_q, state_d;

  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [NUM_CORES-1:0] start_q, start_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic [JOB_W-1:0]     job_q, job_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     core_q, core_d;
  logic [RES_W-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 idle_q, idle_d;

  logic [NUM_CORES-1:0] free, cand, cand_rot;
  logic [IDX_W-1:0]     sel, rot_idx, pick;
  logic [RES_W-1:0]     pick_data;
  logic                 any_free, any_cand, accept;

  // Both operands are below NUM_CORES, so one subtraction wraps.
  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] a,
    input logic [IDX_W-1:0] b
  );
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_W+1)'(NUM_CORES)) s = s - (IDX_W+1)'(NUM_CORES);
    return s[IDX_W-1:0];
  endfunction

  assign free      = ~busy_q;
  assign job_ready = enable & any_free;
  assign accept    = job_valid & job_ready;
  assign cand      = core_done & busy_q;

  priority_encoder #(
    .W  (NUM_CORES),
    .IW (IDX_W)
  ) u_disp_pe (
    .req_i (free),
    .idx_o (sel),
    .any_o (any_free)
  );

  always_comb begin
    cand_rot = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_rot[k] = cand[wrap_add(IDX_W'(k), rr_q)];
    end
  end

  priority_encoder #(
    .W  (NUM_CORES),
    .IW (IDX_W)
  ) u_rr_pe (
    .req_i (cand_rot),
    .idx_o (rot_idx),
    .any_o (any_cand)
  );

  assign pick = wrap_add(rot_idx, rr_q);

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pick == IDX_W'(i)) pick_data = core_result[i*RES_W +: RES_W];
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    start_d = '0;
    ack_d   = '0;
    job_d   = job_q;
    rr_d    = rr_q;
    core_d  = core_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (any_cand) begin
          core_d  = pick;
          data_d  = pick_data;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          ack_d          = NUM_CORES'(1) << core_q;
          busy_d[core_q] = 1'b0;
          rr_d           = wrap_add(core_q, IDX_W'(1));
          valid_d        = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The acked core is still busy here, so sel never collides with it.
    if (accept) begin
      start_d = NUM_CORES'(1) << sel;
      busy_d  = busy_d | start_d;
      job_d   = job_data;
    end
    idle_d = (busy_d == '0) & ~valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= '0;
      start_q <= '0;
      ack_q   <= '0;
      job_q   <= '0;
      rr_q    <= '0;
      core_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      job_q   <= job_d;
      rr_q    <= rr_d;
      core_q  <= core_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      idle_q  <= idle_d;
    end
  end

  assign core_start = start_q;
  assign core_ack   = ack_q;
  assign core_job   = job_q;
  assign res_valid  = valid_q;
  assign res_data   = data_q;
  assign res_core   = core_q;
  assign all_idle   = idle_q;

`ifdef DISPATCH_STATS_EN
  logic [31:0] jobs_q, results_q, stalls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jobs_q    <= '0;
      results_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (accept) jobs_q <= jobs_q + 32'd1;
      if (valid_q & res_ready) results_q <= results_q + 32'd1;
      if (job_valid & ~job_ready) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_jobs    = jobs_q;
  assign stat_results = results_q;
  assign stat_stalls  = stalls_q;
`endif

endmodule

// File: doc/core_dispatcher.md
Name: core_dispatcher

Overview:
- Schedules pixel jobs onto NUM_CORES Mandelbrot iteration cores and collects their results.
- Dispatch: each incoming job goes to the lowest-index free core, selected by priority encoding of the free-core mask.
- Collection: finished results are drained round-robin onto a single valid/ready result stream.
- Position: between the pixel-coordinate generator and the framebuffer writer.

Parameters:
- NUM_CORES, 10, number of iteration cores.
- JOB_W, 32, job payload width (packed x/y coordinate).
- RES_W, 16, result width (iteration count).
- IDX_W, 4, core index width; must satisfy 2**IDX_W >= NUM_CORES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allows new dispatches.
- job_valid  in  1  job offered.
- job_ready  out  1  job accepted this cycle when both valid and ready are high.
- job_data  in  JOB_W  job payload.
- core_start  out  NUM_CORES  one-hot, one-cycle start pulse.
- core_job  out  JOB_W  payload broadcast to all cores; meaningful with core_start.
- core_done  in  NUM_CORES  level; held high by a core until it is acked.
- core_result  in  NUM_CORES*RES_W  flattened; core i occupies bits [i*RES_W +: RES_W].
- core_ack  out  NUM_CORES  one-hot, one-cycle pulse; releases the core.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts.
- res_data  out  RES_W  result value.
- res_core  out  IDX_W  index of the core that produced res_data.
- all_idle  out  1  no busy cores and no pending result.

Behaviour:
- Reset (async, rst_n low): all outputs 0 except all_idle=1; busy_q=0; rr_ptr=0; collector state=IDLE.
- Reset asserted mid-operation: in-flight jobs are abandoned and cores are not acked; core resets are tied to the same rst_n.
- Busy tracking: busy_q[NUM_CORES] is owned by this block.
  - Bit set on the edge that issues core_start.
  - Bit cleared on the edge that issues core_ack.
- Dispatch select:
  - free = ~busy_q.
  - job_ready = enable & |free, combinational from registers only.
  - sel = lowest set bit of free.
- Job accept (job_valid & job_ready), on the next edge:
  - core_start[sel]=1 for exactly one cycle.
  - core_job is registered from job_data.
  - busy_q[sel] is set.
  - Latency is 1 cycle, and back-to-back jobs are allowed every cycle until every core is busy.
- core_job holds its last value when no start is issued.
- A core freed by core_ack is not dispatchable until the cycle after the ack; free is computed from registered busy_q.
- Collector FSM, states IDLE and HOLD:
  - IDLE: cand = core_done & busy_q. If cand is nonzero, pick the first set bit at or after rr_ptr, wrapping modulo NUM_CORES. Latch res_data and res_core, set res_valid=1, go to HOLD.
  - HOLD: res_valid, res_data and res_core stay stable until res_ready. On res_valid & res_ready:
    - core_ack[res_core]=1 for one cycle (next edge).
    - busy_q[res_core] cleared.
    - rr_ptr = (res_core+1) mod NUM_CORES, with wrap at NUM_CORES-1 to 0.
    - res_valid=0, return to IDLE.
- Throughput: at most one result per 2 cycles.
- core_done is ignored for cores whose busy_q bit is 0. This masks the stale done level in the cycle of and after the ack.
- Ack and start in the same edge: no conflict, because the acked core is busy and therefore cannot be selected for dispatch.
- enable low: blocks new dispatches only; results continue to drain.
- all_idle = (busy_q==0) & ~res_valid, registered.

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- When defined, adds three 32-bit output ports:
  - stat_jobs: counts accepted jobs.
  - stat_results: counts result handshakes.
  - stat_stalls: counts cycles with job_valid & ~job_ready.
- All three reset to 0 and wrap at 2**32.
- Without the macro, the ports and counters are absent and there is no other behavioural change.

Decomposition:
- Shared package fractal_pkg holds NUM_CORES, JOB_W, RES_W and IDX_W defaults, plus the collector state enum (IDLE, HOLD).
- Sub-module: the existing priority_encoder (lowest set bit wins, with an any-bit-set flag), instantiated twice.
  - Dispatch select: on the free mask.
  - Round-robin collector: on cand rotated right by rr_ptr; the encoder output is added to rr_ptr modulo NUM_CORES.

Test Plan:
- Reset, then 10 jobs on consecutive cycles with enable=1:
  - core_start pulses 0x001, 0x002, … 0x200 on consecutive cycles.
  - job_ready=0 after the 10th job.
  - all_idle=0.
- With all cores busy, assert core_done=0x208 (cores 3 and 9) with results 0x0011 and 0x0022, res_ready=1, rr_ptr=0:
  - res_core=3 first, then 9.
  - core_ack pulses 0x008, then 0x200.
  - rr_ptr ends at 0 (wrap).
- res_ready held low for 5 cycles while res_valid=1:
  - res_data and res_core stay stable.
  - No core_ack is issued.
  - busy_q is unchanged.
- Core 4 acked, with a job pending in the same cycle:
  - job_ready rises the next cycle.
  - The job goes to core 4 (core_start=0x010).
  - A stale core_done[4] in the ack cycle produces no second result.
- enable=0 with job_valid=1 and 3 cores done:
  - No core_start is issued.
  - All 3 results drain.
  - With DISPATCH_STATS_EN defined, stat_stalls increments every cycle.
- rst_n pulsed low asynchronously mid-dispatch (no clock edge):
  - Outputs go to reset values immediately.
  - all_idle=1.
  - The next job goes to core 0.
